// File: rtl/anode_scan_ctrl_pkg.sv
// Shared constants, FSM encoding and hex-to-segment table for the 7-segment scan controller.
// Segment codes are active-low {g,f,e,d,c,b,a}.
package anode_scan_ctrl_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [7:0] AN_OFF    = 8'hFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } state_e;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] code;
        case (hex)
            4'h0:    code = 7'h40;
            4'h1:    code = 7'h79;
            4'h2:    code = 7'h24;
            4'h3:    code = 7'h30;
            4'h4:    code = 7'h19;
            4'h5:    code = 7'h12;
            4'h6:    code = 7'h02;
            4'h7:    code = 7'h78;
            4'h8:    code = 7'h00;
            4'h9:    code = 7'h10;
            4'hA:    code = 7'h08;
            4'hB:    code = 7'h03;
            4'hC:    code = 7'h46;
            4'hD:    code = 7'h21;
            4'hE:    code = 7'h06;
            default: code = 7'h0E;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/anode_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decode (lowercase b and d).
module hex_to_seg7
    import anode_scan_ctrl_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex_to_seg(hex);
    end

endmodule

// File: rtl/anode_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-digit blanking dead-time, frame-aligned
// shadow update of display data, registered anode/segment/DP outputs.
module anode_scan_ctrl
    import anode_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int BLANK_CYCLES = 4,
    parameter int IDX_W        = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    scan_tick,
    input  logic [4*NUM_DIGITS-1:0] digit_data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_mask,
    input  logic                    upd_req,
    output logic                    upd_ack,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_start,
    output state_e                  dbg_state
);

    localparam int                     CNT_W      = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]       IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0]  AN_ALL_OFF = AN_OFF[NUM_DIGITS-1:0];

    state_e                  state, state_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic [CNT_W-1:0]        bcnt, bcnt_n;
    logic [4*NUM_DIGITS-1:0] data_sh;
    logic [NUM_DIGITS-1:0]   dp_sh;
    logic [NUM_DIGITS-1:0]   mask_sh;

    logic       frame_wrap;
    logic       blank_done;
    logic       take_upd;
    logic       drive_on;
    logic [3:0] cur_nibble;
    logic [6:0] cur_seg;

    assign dbg_state = state;

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        bcnt_n     = bcnt;
        frame_wrap = 1'b0;
        blank_done = 1'b0;
        if (!en) begin
            state_n = IDLE;
            idx_n   = '0;
            bcnt_n  = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_n = BLANK;
                    idx_n   = '0;
                    bcnt_n  = '0;
                end
                BLANK: begin
                    // Ticks are deliberately not looked at here: a tick during dead-time is dropped.
                    if (bcnt == CNT_LAST) begin
                        state_n    = DRIVE;
                        bcnt_n     = '0;
                        blank_done = 1'b1;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end
                DRIVE: begin
                    if (scan_tick) begin
                        state_n = BLANK;
                        bcnt_n  = '0;
                        if (idx == IDX_LAST) begin
                            idx_n      = '0;
                            frame_wrap = 1'b1;
                        end else begin
                            idx_n = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = IDLE;
                    idx_n   = '0;
                    bcnt_n  = '0;
                end
            endcase
        end
    end

    // Handshake: upd_req is a level held (with stable data) until upd_ack is seen; the shadow
    // is loaded on the cycle a request meets IDLE or a frame wrap, and upd_ack pulses one cycle later.
    assign take_upd = upd_req && ((state == IDLE) || frame_wrap);

    assign cur_nibble = data_sh[{idx, 2'b00} +: 4];
    assign drive_on   = en && (state == DRIVE) && mask_sh[idx];

    hex_to_seg7 u_dec (
        .hex (cur_nibble),
        .seg (cur_seg)
    );

    // Outputs are decoded from the current state, so they trail state by one clock;
    // en low overrides that lag and blanks on the very next edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idx         <= '0;
            bcnt        <= '0;
            data_sh     <= '0;
            dp_sh       <= '0;
            mask_sh     <= '0;
            upd_ack     <= 1'b0;
            an          <= AN_ALL_OFF;
            seg         <= SEG_BLANK;
            dp          <= 1'b1;
            digit_idx   <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            bcnt        <= bcnt_n;
            upd_ack     <= take_upd;
            if (take_upd) begin
                data_sh <= digit_data;
                dp_sh   <= dp_in;
                mask_sh <= digit_mask;
            end
            an          <= drive_on ? ~(NUM_DIGITS'(1) << idx) : AN_ALL_OFF;
            seg         <= drive_on ? cur_seg : SEG_BLANK;
            dp          <= drive_on ? ~dp_sh[idx] : 1'b1;
            digit_idx   <= en ? idx : '0;
            frame_start <= blank_done && (idx == '0);
        end
    end

endmodule

// File: tb/tb_anode_scan_ctrl.sv
// Directed bench for anode_scan_ctrl: scan walk, frame-aligned update, masking,
// enable drop, ignored dead-time ticks and asynchronous reset.
module tb_anode_scan_ctrl;
    import anode_scan_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        scan_tick;
    logic [31:0] digit_data;
    logic [7:0]  dp_in;
    logic [7:0]  digit_mask;
    logic        upd_req;
    logic        upd_ack;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [2:0]  digit_idx;
    logic        frame_start;
    state_e      dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    anode_scan_ctrl #(
        .NUM_DIGITS   (8),
        .BLANK_CYCLES (4),
        .IDX_W        (3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .scan_tick   (scan_tick),
        .digit_data  (digit_data),
        .dp_in       (dp_in),
        .digit_mask  (digit_mask),
        .upd_req     (upd_req),
        .upd_ack     (upd_ack),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .digit_idx   (digit_idx),
        .frame_start (frame_start),
        .dbg_state   (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_blanked(input string tag);
        check({tag, "_an"},  32'(an),  32'hFF);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dp"},  32'(dp),  32'h1);
    endtask

    // One 20-clock digit slot: optional tick, 4-clock dead gap, then the driven digit.
    task automatic slot(input bit do_tick, input bit extra_tick, input logic [2:0] nidx,
                        input logic [7:0] exp_an, input logic [6:0] exp_seg,
                        input logic exp_dp, input logic exp_ack);
        if (do_tick) scan_tick = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
        check($sformatf("ack_p0_d%0d", nidx), 32'(upd_ack), 32'(exp_ack));
        check($sformatf("state_p0_d%0d", nidx), 32'(dbg_state), 32'(BLANK));
        if (exp_ack) upd_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            if (extra_tick && c == 1) scan_tick = 1'b1;
            @(negedge clk);
            scan_tick = 1'b0;
            check_blanked($sformatf("gap%0d_d%0d", c, nidx));
            check($sformatf("gap%0d_idx_d%0d", c, nidx), 32'(digit_idx), 32'(nidx));
            check($sformatf("gap%0d_ack_d%0d", c, nidx), 32'(upd_ack), 32'h0);
            check($sformatf("gap%0d_fs_d%0d", c, nidx), 32'(frame_start),
                  32'((c == 4) && (nidx == 3'd0)));
        end
        @(negedge clk);
        check($sformatf("an_d%0d", nidx),  32'(an),  32'(exp_an));
        check($sformatf("seg_d%0d", nidx), 32'(seg), 32'(exp_seg));
        check($sformatf("dp_d%0d", nidx),  32'(dp),  32'(exp_dp));
        check($sformatf("fs_drv_d%0d", nidx), 32'(frame_start), 32'h0);
        repeat (14) @(negedge clk);
        check($sformatf("an_hold_d%0d", nidx), 32'(an), 32'(exp_an));
        check($sformatf("idx_hold_d%0d", nidx), 32'(digit_idx), 32'(nidx));
    endtask

    initial begin
        rst        = 1'b0;
        en         = 1'b0;
        scan_tick  = 1'b0;
        digit_data = '0;
        dp_in      = '0;
        digit_mask = '0;
        upd_req    = 1'b0;
        repeat (3) @(negedge clk);
        check_blanked("rst");
        check("rst_idx",   32'(digit_idx),   32'h0);
        check("rst_ack",   32'(upd_ack),     32'h0);
        check("rst_fs",    32'(frame_start), 32'h0);
        check("rst_state", 32'(dbg_state),   32'(IDLE));

        // Commit the first frame while idle.
        rst = 1'b1;
        @(negedge clk);
        digit_data = 32'h76543210;
        dp_in      = 8'h81;
        digit_mask = 8'hFF;
        upd_req    = 1'b1;
        @(negedge clk);
        check("idle_ack", 32'(upd_ack), 32'h1);
        upd_req = 1'b0;
        @(negedge clk);
        check("idle_ack_drop", 32'(upd_ack), 32'h0);
        check_blanked("idle");

        // Scan walk through a full frame and its wrap.
        en = 1'b1;
        slot(1'b0, 1'b0, 3'd0, 8'hFE, 7'h40, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++)
            slot(1'b1, 1'b0, 3'(i), ~(8'd1 << i), seg_tab[i], (i == 7) ? 1'b0 : 1'b1, 1'b0);
        slot(1'b1, 1'b0, 3'd0, 8'hFE, 7'h40, 1'b0, 1'b0);

        // Mid-frame request is held off until the frame wraps.
        slot(1'b1, 1'b0, 3'd1, 8'hFD, 7'h79, 1'b1, 1'b0);
        slot(1'b1, 1'b0, 3'd2, 8'hFB, 7'h24, 1'b1, 1'b0);
        slot(1'b1, 1'b0, 3'd3, 8'hF7, 7'h30, 1'b1, 1'b0);
        digit_data = 32'hFFFFFFFF;
        upd_req    = 1'b1;
        for (int i = 4; i < 8; i++)
            slot(1'b1, 1'b0, 3'(i), ~(8'd1 << i), seg_tab[i], (i == 7) ? 1'b0 : 1'b1, 1'b0);
        slot(1'b1, 1'b0, 3'd0, 8'hFE, 7'h0E, 1'b0, 1'b1);
        slot(1'b1, 1'b0, 3'd1, 8'hFD, 7'h0E, 1'b1, 1'b0);

        // A tick inside the dead gap is dropped; the slot still lasts until the next tick.
        slot(1'b1, 1'b1, 3'd2, 8'hFB, 7'h0E, 1'b1, 1'b0);
        slot(1'b1, 1'b0, 3'd3, 8'hF7, 7'h0E, 1'b1, 1'b0);

        // Enable drop at digit 5 together with a tick: enable wins.
        slot(1'b1, 1'b0, 3'd4, 8'hEF, 7'h0E, 1'b1, 1'b0);
        slot(1'b1, 1'b0, 3'd5, 8'hDF, 7'h0E, 1'b1, 1'b0);
        en        = 1'b0;
        scan_tick = 1'b1;
        @(negedge clk);
        scan_tick = 1'b0;
        check_blanked("en_off");
        check("en_off_idx",   32'(digit_idx), 32'h0);
        check("en_off_state", 32'(dbg_state), 32'(IDLE));
        check("en_off_ack",   32'(upd_ack),   32'h0);
        repeat (3) @(negedge clk);
        check_blanked("en_off_hold");
        en = 1'b1;
        slot(1'b0, 1'b0, 3'd0, 8'hFE, 7'h0E, 1'b0, 1'b0);

        // Mask the upper four digits from the next frame on.
        digit_data = 32'h76543210;
        digit_mask = 8'h0F;
        upd_req    = 1'b1;
        for (int i = 1; i < 8; i++)
            slot(1'b1, 1'b0, 3'(i), ~(8'd1 << i), 7'h0E, (i == 7) ? 1'b0 : 1'b1, 1'b0);
        slot(1'b1, 1'b0, 3'd0, 8'hFE, 7'h40, 1'b0, 1'b1);
        for (int i = 1; i < 8; i++) begin
            if (i < 4)
                slot(1'b1, 1'b0, 3'(i), ~(8'd1 << i), seg_tab[i], 1'b1, 1'b0);
            else
                slot(1'b1, 1'b0, 3'(i), 8'hFF, 7'h7F, 1'b1, 1'b0);
        end
        slot(1'b1, 1'b0, 3'd0, 8'hFE, 7'h40, 1'b0, 1'b0);

        // Asynchronous reset mid-drive with a pending request.
        slot(1'b1, 1'b0, 3'd1, 8'hFD, 7'h79, 1'b1, 1'b0);
        upd_req = 1'b1;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_blanked("arst");
        check("arst_idx",   32'(digit_idx),   32'h0);
        check("arst_ack",   32'(upd_ack),     32'h0);
        check("arst_fs",    32'(frame_start), 32'h0);
        check("arst_state", 32'(dbg_state),   32'(IDLE));
        upd_req = 1'b0;
        en      = 1'b0;
        @(negedge clk);
        check("arst_ack_hold", 32'(upd_ack), 32'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_ack", 32'(upd_ack), 32'h0);
        check_blanked("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
